// File: rtl/core_pkg.sv
// Shared definitions for the pipelined core's ID/EX operand stage.
//   REG_ADDR_W : width of a register index (8 architectural registers)
//   CORE_XLEN  : datapath width carried in the ID/EX record
//   FWD_*      : forward-select encodings produced by the forwarding unit
//   id_ex_t    : the ID/EX pipeline record (controls, indices, operands)
package core_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int CORE_XLEN  = 16;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memread;
        logic                  alusrc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [CORE_XLEN-1:0]  rd1;
        logic [CORE_XLEN-1:0]  rd2;
        logic [CORE_XLEN-1:0]  imm;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of every non-clock/reset signal of the ID/EX operand stage.
//   ID side      : id_valid, id_rs1/rs2/rd, id_regwrite, id_memread,
//                  id_alusrc, id_rd1/rd2, id_imm, flush
//   Forwarding   : forward_A/B selects, ex_mem_result, mem_wb_result in;
//                  ex_rs1/ex_rs2 out to the forwarding unit
//   EX side      : ex_valid/regwrite/memread, ex_rd, alu_a, alu_b, store_data
//   Hazard       : stall, stall_count
// modport slave is the stage itself; modport master is its environment.
interface id_ex_operand_stage_if
    import core_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int CNT_W = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_alusrc;
    logic [XLEN-1:0]       id_rd1;
    logic [XLEN-1:0]       id_rd2;
    logic [XLEN-1:0]       id_imm;
    logic                  flush;
    logic [1:0]            forward_A;
    logic [1:0]            forward_B;
    logic [XLEN-1:0]       ex_mem_result;
    logic [XLEN-1:0]       mem_wb_result;

    logic                  ex_valid;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;
    logic [XLEN-1:0]       store_data;
    logic                  stall;
    logic [CNT_W-1:0]      stall_count;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread,
               id_alusrc, id_rd1, id_rd2, id_imm, flush, forward_A,
               forward_B, ex_mem_result, mem_wb_result,
        output ex_valid, ex_regwrite, ex_memread, ex_rs1, ex_rs2, ex_rd,
               alu_a, alu_b, store_data, stall, stall_count
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread,
               id_alusrc, id_rd1, id_rd2, id_imm, flush, forward_A,
               forward_B, ex_mem_result, mem_wb_result,
        input  ex_valid, ex_regwrite, ex_memread, ex_rs1, ex_rs2, ex_rd,
               alu_a, alu_b, store_data, stall, stall_count
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// Forwarding mux for one EX operand.
//   sel     : forward select (FWD_REG / FWD_WB / FWD_MEM; 2'b11 = regfile)
//   reg_val : registered regfile value
//   wb_val  : MEM/WB result
//   mem_val : EX/MEM result
//   out     : selected operand
module operand_fwd_mux
    import core_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] reg_val,
    input  logic [XLEN-1:0] wb_val,
    input  logic [XLEN-1:0] mem_val,
    output logic [XLEN-1:0] out
);

    always_comb begin
        out = reg_val;
        case (sel)
            FWD_WB:  out = wb_val;
            FWD_MEM: out = mem_val;
            default: out = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus EX operand selection and load-use hazard
// detection.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : id_ex_operand_stage_if.slave (ID fields, forwarding selects
//              and values in; registered controls/indices, ALU operands,
//              store data, stall and the saturating stall counter out)
// XLEN must equal core_pkg::CORE_XLEN since the ID/EX record is fixed-width.
module id_ex_operand_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);

    id_ex_t           ex_d;
    id_ex_t           ex_p1;
    logic             stall_c;
    logic [CNT_W-1:0] stall_cnt_p1;
    logic [XLEN-1:0]  alu_a_c;
    logic [XLEN-1:0]  store_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A load in EX whose destination feeds the ID instruction; register 0 is
    // an ordinary register here, so no zero-index exclusion.
    assign stall_c = ex_p1.valid & ex_p1.memread & ex_p1.regwrite & bus.id_valid &
                     ((ex_p1.rd == bus.id_rs1) | (ex_p1.rd == bus.id_rs2));

    // Flush and stall both load an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (!bus.flush && !stall_c) begin
            ex_d.valid    = bus.id_valid;
            ex_d.regwrite = bus.id_regwrite;
            ex_d.memread  = bus.id_memread;
            ex_d.alusrc   = bus.id_alusrc;
            ex_d.rs1      = bus.id_rs1;
            ex_d.rs2      = bus.id_rs2;
            ex_d.rd       = bus.id_rd;
            ex_d.rd1      = bus.id_rd1;
            ex_d.rd2      = bus.id_rd2;
            ex_d.imm      = bus.id_imm;
        end
    end

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_p1        <= '0;
            stall_cnt_p1 <= '0;
        end else begin
            ex_p1 <= ex_d;
            if (stall_c && !bus.flush)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .sel     (bus.forward_A),
        .reg_val (ex_p1.rd1),
        .wb_val  (bus.mem_wb_result),
        .mem_val (bus.ex_mem_result),
        .out     (alu_a_c)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .sel     (bus.forward_B),
        .reg_val (ex_p1.rd2),
        .wb_val  (bus.mem_wb_result),
        .mem_val (bus.ex_mem_result),
        .out     (store_c)
    );

    assign bus.ex_valid    = ex_p1.valid;
    assign bus.ex_regwrite = ex_p1.regwrite;
    assign bus.ex_memread  = ex_p1.memread;
    assign bus.ex_rs1      = ex_p1.rs1;
    assign bus.ex_rs2      = ex_p1.rs2;
    assign bus.ex_rd       = ex_p1.rd;
    assign bus.alu_a       = alu_a_c;
    assign bus.store_data  = store_c;
    assign bus.alu_b       = ex_p1.alusrc ? ex_p1.imm : store_c;
    assign bus.stall       = stall_c;
    assign bus.stall_count = stall_cnt_p1;

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and EX-stage operand selector for the 3-bit-register-address pipelined core. It captures decoded operands from ID each cycle and presents the registered source indices to the forwarding unit. It then muxes regfile, EX/MEM or MEM/WB data onto the ALU operands using the unit's `forward_A`/`forward_B` selects. It also detects load-use hazards against the instruction in EX, stalls IF/ID, inserts one bubble, and counts stall cycles.

## Interface
- `XLEN`, 16, datapath width of operands, immediates and results
- `CNT_W`, 16, width of the saturating stall counter
- `clk` in 1: single clock; all state updates on posedge
- `rst` in 1: asynchronous, active-high reset
- `id_valid` in 1: ID holds a real instruction
- `id_rs1`, `id_rs2`, `id_rd` in 3 each: decoded register indices
- `id_regwrite` in 1: instruction writes `id_rd`
- `id_memread` in 1: instruction is a load (drives ResultSrc in MEM)
- `id_alusrc` in 1: ALU operand B takes the immediate
- `id_rd1`, `id_rd2` in XLEN each: regfile read data
- `id_imm` in XLEN: sign-extended immediate
- `flush` in 1: branch redirect; kill the instruction entering EX
- `forward_A`, `forward_B` in 2 each: selects from the forwarding unit
- `ex_mem_result`, `mem_wb_result` in XLEN each: forwarded values
- `ex_valid`, `ex_regwrite`, `ex_memread` out 1 each: registered controls
- `ex_rs1`, `ex_rs2`, `ex_rd` out 3 each: registered indices; `ex_rs1`/`ex_rs2` feed the forwarding unit
- `alu_a`, `alu_b` out XLEN each: final ALU operands
- `store_data` out XLEN: forwarded rs2 value, before the immediate mux
- `stall` out 1: hold PC and IF/ID this cycle
- `stall_count` out CNT_W: number of load-use stall cycles since reset

## Operation
- **Load-use detect (combinational).**
  - `stall = ex_valid & ex_memread & ex_regwrite & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
  - All 8 registers participate; there is no hardwired-zero register.
- **ID/EX update priority per posedge.** Highest first:
  - `rst`: clear everything.
  - `flush`: load a bubble.
  - `stall`: load a bubble.
  - Otherwise: capture all `id_*` fields.
- **Bubble.** `ex_valid`, `ex_regwrite` and `ex_memread` are all 0. Index and data fields are don't-care but are held at 0.
- **Operand A.**
  - 00 → registered rd1.
  - 01 → `mem_wb_result`.
  - 10 → `ex_mem_result`.
  - 11 → registered rd1.
- **Store data.** Same selection as operand A, using `forward_B` and registered rd2.
- **Operand B.** `alu_b = ex_alusrc ? ex_imm : store_data`.
- **Stall counter.** Increments on each posedge where `stall=1` and `flush=0`. It saturates at all-ones and never wraps.
- **Simultaneous `flush` and `stall`.** `flush` wins. A bubble is inserted and the counter does not increment.
  - `stall` still asserts combinationally; the upstream flush overrides the PC.

## Timing
- **Reset values.** Asynchronous; all outputs below apply immediately on `rst`.
  - `ex_valid`, `ex_regwrite` and `ex_memread` are 0.
  - `ex_rs1`, `ex_rs2` and `ex_rd` are 0.
  - `alu_a`, `alu_b` and `store_data` are 0, since the registered data is 0 and the selects at reset pick the regfile path.
  - `stall_count` is 0.
  - `stall` is 0 because `ex_valid` is 0.
- **Latency.** `id_*` appear on `ex_*` 1 cycle after the capturing edge.
- **Operand path.** `alu_a`, `alu_b` and `store_data` are combinational from the registered fields and the same-cycle selects.
- **Stall duration.** Exactly one cycle per load-use hazard. After the bubble, `ex_memread=0`, so `stall` deasserts and the held ID instruction is captured on the next edge.
- **Reset mid-stall.** `stall` drops immediately, the bubble is discarded and the counter clears.

## Structure
- **Shared package `core_pkg`.**
  - `REG_ADDR_W = 3`.
  - Forward-select constants `FWD_REG = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`.
  - Packed struct `id_ex_t` holding valid, regwrite, memread, alusrc, rs1, rs2, rd, rd1, rd2 and imm.
- **Sub-module `operand_fwd_mux`.** Parameterised by XLEN, inputs sel[1:0], reg_val, wb_val and mem_val. Instantiated twice: A path and store-data path.
- **Top level.** Holds the `id_ex_t` register, the load-use comparator and the saturating counter.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle with `ex_valid=1` → all outputs 0 before the next edge; `stall_count=0`.
- **Plain capture.** `id_rs1=2`, `id_rs2=5`, `id_rd=3`, `id_rd1=0x1111`, `id_imm=0x0004`, `id_alusrc=1`, selects 00 → next cycle `ex_rs1=2`, `ex_rs2=5`, `alu_a=0x1111`, `alu_b=0x0004`.
- **Forwarding.** `forward_A=10` with `ex_mem_result=0xBEEF` → `alu_a=0xBEEF`. `forward_B=01` with `mem_wb_result=0x1234`, `alusrc=0` → `alu_b=0x1234` and `store_data=0x1234`. `forward_A=11` → registered rd1.
- **Load-use.** EX holds a load with `ex_rd=4`; ID has `id_rs2=4` → `stall=1` for one cycle, next `ex_valid=0`, `stall_count=1`. The ID instruction is captured the following cycle and `stall=0`.
- **Flush during stall.** `flush=1` with the same hazard → bubble inserted, `stall_count` unchanged.
- **Saturation.** With `CNT_W=4`, force 20 consecutive stall cycles → `stall_count` stops at 15.
